// File: rtl/adxl345_pkg.sv
// adxl345_pkg: register map, reset constants and FSM states shared by the ADXL345 SPI responder
package adxl345_pkg;
  localparam logic [5:0] DEVID       = 6'h00;
  localparam logic [5:0] BW_RATE     = 6'h2C;
  localparam logic [5:0] POWER_CTL   = 6'h2D;
  localparam logic [5:0] INT_ENABLE  = 6'h2E;
  localparam logic [5:0] INT_SOURCE  = 6'h30;
  localparam logic [5:0] DATA_FORMAT = 6'h31;
  localparam logic [5:0] DATAX0      = 6'h32;
  localparam logic [5:0] DATAX1      = 6'h33;
  localparam logic [5:0] DATAY0      = 6'h34;
  localparam logic [5:0] DATAY1      = 6'h35;
  localparam logic [5:0] DATAZ0      = 6'h36;
  localparam logic [5:0] DATAZ1      = 6'h37;
  localparam logic [5:0] FIFO_STATUS = 6'h39;
  localparam logic [7:0] BW_RATE_RST = 8'h0A;
  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;
  function automatic logic is_read_only(input logic [5:0] a);
    return a == DEVID || a == INT_SOURCE || (a >= DATAX0 && a <= DATAZ1) || a == FIFO_STATUS;
  endfunction
  // Reserved block 0x01-0x1C also drops writes so it always reads back 0
  function automatic logic is_writable(input logic [5:0] a);
    return !is_read_only(a) && !(a >= 6'h01 && a <= 6'h1C);
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchronises SPI pins into the clk domain and derives sclk/cs edge strobes
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic sdio,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_s,
  output logic sdio_s
);
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, sdio_q;
  logic sclk_d, cs_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= '1;
      cs_q   <= '1;
      sdio_q <= '0;
      sclk_d <= 1'b1;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sdio_q <= {sdio_q[SYNC_STAGES-2:0], sdio};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_d;
  assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_d;
  assign cs_n_s    = cs_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_q[SYNC_STAGES-1];
endmodule

// File: rtl/adxl345_spi_responder.sv
// adxl345_spi_responder: 3-wire SPI slave emulating the ADXL345 register file, sample data and INT1
module adxl345_spi_responder
  import adxl345_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_VAL   = 8'hE5
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdio_in,
  output logic        spi_sdio_out,
  output logic        spi_sdio_oe,
  output logic        int1,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, sdio_s;
  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh;
  logic [5:0]  addr;
  logic        mb;
  logic [7:0]  regs [64];
  logic [47:0] shadow;
  logic        pending;
  logic        copy, rd_clr;
  logic [7:0]  wr_data;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_clk), .rst_n(reset_reset_n), .sclk(spi_sclk), .cs_n(spi_cs_n), .sdio(spi_sdio_in),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_fall(cs_fall), .cs_rise(cs_rise),
    .cs_n_s(cs_n_s), .sdio_s(sdio_s)
  );

  // Samples land in the data registers only while deselected so multi-byte reads stay coherent
  assign copy    = pending & cs_n_s;
  assign rd_clr  = state == RD && sclk_rise && bit_cnt == 3'd7 && addr == DATAZ1;
  assign wr_data = {sh[6:0], sdio_s};

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      sh           <= '0;
      addr         <= '0;
      mb           <= 1'b0;
      spi_sdio_out <= 1'b0;
      spi_sdio_oe  <= 1'b0;
      int1         <= 1'b0;
      shadow       <= '0;
      pending      <= 1'b0;
      for (int i = 0; i < 64; i++) regs[i] <= '0;
      regs[DEVID]   <= DEVID_VAL;
      regs[BW_RATE] <= BW_RATE_RST;
    end else begin
      int1    <= |(regs[INT_SOURCE] & regs[INT_ENABLE]);
      pending <= sample_valid | (pending & ~copy);
      if (sample_valid) shadow <= {sample_x, sample_y, sample_z};
      if (copy) begin
        regs[DATAX0] <= shadow[39:32];
        regs[DATAX1] <= shadow[47:40];
        regs[DATAY0] <= shadow[23:16];
        regs[DATAY1] <= shadow[31:24];
        regs[DATAZ0] <= shadow[7:0];
        regs[DATAZ1] <= shadow[15:8];
      end
      regs[INT_SOURCE] <= {copy | (regs[INT_SOURCE][7] & ~rd_clr), 6'd0,
                           (copy & regs[INT_SOURCE][7]) | (regs[INT_SOURCE][0] & ~rd_clr)};
      if (cs_rise) begin
        state        <= IDLE;
        bit_cnt      <= '0;
        spi_sdio_oe  <= 1'b0;
        spi_sdio_out <= 1'b0;
      end else if (cs_fall) begin
        state   <= CMD;
        bit_cnt <= '0;
      end else if (sclk_rise && state != IDLE) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (state != RD) sh <= wr_data;
        if (bit_cnt == 3'd7) begin
          if (state == CMD) begin
            state <= sh[6] ? RD : WR;
            addr  <= wr_data[5:0];
            mb    <= sh[5];
          end else begin
            addr <= addr + 6'(mb);
            if (state == WR && is_writable(addr)) regs[addr] <= wr_data;
          end
        end
      end else if (sclk_fall && state == RD) begin
        spi_sdio_oe <= 1'b1;
        {spi_sdio_out, sh} <= bit_cnt == 3'd0 ? {regs[addr], 1'b0} : {sh, 1'b0};
      end
    end
endmodule

// File: tb/tb_adxl345_spi_responder.sv
// tb_adxl345_spi_responder: randomized SPI master against a transaction-level register model
module tb_adxl345_spi_responder;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b1, cs_n = 1'b1, mst_drv = 1'b0, sample_valid = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic sdio_out, sdio_oe, int1, sdio_pad;
  int tests = 0, fails = 0, quiet = 0;
  bit active = 1'b1;
  logic [7:0] m_reg [64];
  logic [15:0] m_sx, m_sy, m_sz;
  bit m_pend = 1'b0;
  logic [7:0] rx [$];
  logic [7:0] tx [$];
  logic [7:0] exp6 [6];

  always #10 clk = ~clk;
  assign sdio_pad = sdio_oe ? sdio_out : mst_drv;

  adxl345_spi_responder dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_sdio_in(sdio_pad),
    .spi_sdio_out(sdio_out), .spi_sdio_oe(sdio_oe), .int1(int1), .sample_valid(sample_valid),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_wr(input int a);
    return !(a == 0 || (a >= 1 && a <= 28) || a == 48 || (a >= 50 && a <= 55) || a == 57);
  endfunction

  function automatic int hp();
    return int'($urandom_range(6, 9));
  endfunction

  task automatic m_copy();
    m_reg[50] = m_sx[7:0];
    m_reg[51] = m_sx[15:8];
    m_reg[52] = m_sy[7:0];
    m_reg[53] = m_sy[15:8];
    m_reg[54] = m_sz[7:0];
    m_reg[55] = m_sz[15:8];
    if (m_reg[48][7]) m_reg[48][0] = 1'b1;
    m_reg[48][7] = 1'b1;
    m_pend = 1'b0;
  endtask

  task automatic half(input int n, input bit ds);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = ds && i == 0;
    end
    sample_valid = 1'b0;
  endtask

  task automatic do_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    active = 1'b1;
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_sx = x; m_sy = y; m_sz = z;
    m_copy();
    half(3, 1'b0);
    active = 1'b0;
  endtask

  task automatic noise();
    active = 1'b1;
    repeat (4) begin
      sclk = 1'b0; half(7, 1'b0);
      sclk = 1'b1; half(7, 1'b0);
    end
    active = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input int nbytes, input int part, input int samp_at);
    int a, nb;
    logic [7:0] d, r;
    bit oe_seen, oe_ok, ds;
    active = 1'b1;
    rx.delete();
    @(negedge clk);
    cs_n = 1'b0;
    half(8, 1'b0);
    oe_seen = 1'b0;
    for (int b = 0; b < 8; b++) begin
      sclk = 1'b0; mst_drv = cmd[7-b]; half(hp(), 1'b0);
      oe_seen |= sdio_oe;
      sclk = 1'b1; half(hp(), 1'b0);
    end
    check("cmd_oe", 32'(oe_seen), 0);
    a = int'(cmd[5:0]);
    for (int k = 0; k < nbytes + (part > 0 ? 1 : 0); k++) begin
      nb = k < nbytes ? 8 : part;
      d = k < tx.size() ? tx[k] : 8'h00;
      r = '0;
      oe_ok = 1'b1;
      for (int i = 0; i < nb; i++) begin
        sclk = 1'b0;
        mst_drv = cmd[7] ? 1'($urandom) : d[7-i];
        ds = k == samp_at && i == 3;
        half(hp(), ds);
        if (ds) begin
          m_sx = sample_x; m_sy = sample_y; m_sz = sample_z; m_pend = 1'b1;
        end
        r[7-i] = sdio_out;
        oe_ok &= sdio_oe;
        sclk = 1'b1; half(hp(), 1'b0);
      end
      if (nb == 8) begin
        if (cmd[7]) begin
          check("rd_byte", 32'(r), 32'(m_reg[a]));
          check("rd_oe", 32'(oe_ok), 1);
          rx.push_back(r);
          if (a == 55) m_reg[48] = m_reg[48] & 8'h7E;
        end else if (m_wr(a)) m_reg[a] = d;
        a = cmd[6] ? (a + 1) % 64 : a;
      end
    end
    half(hp(), 1'b0);
    cs_n = 1'b1;
    if (m_pend) m_copy();
    half(4, 1'b0);
    check("cs_oe_off", 32'(sdio_oe), 0);
    half(6, 1'b0);
    active = 1'b0;
  endtask

  // Once the bus has been idle long enough, int1 and oe must match the model exactly
  always @(negedge clk) begin
    quiet = (active || !rst_n) ? 0 : quiet + 1;
    if (quiet >= 8) begin
      check("int1", 32'(int1), 32'(|(m_reg[48] & m_reg[46])));
      check("idle_oe", 32'(sdio_oe), 0);
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[0]  = 8'hE5;
    m_reg[44] = 8'h0A;
    half(3, 1'b0);
    check("rst_oe", 32'(sdio_oe), 0);
    check("rst_out", 32'(sdio_out), 0);
    check("rst_int1", 32'(int1), 0);
    rst_n = 1'b1;
    half(4, 1'b0);
    // T1 and full reset map
    frame(8'h80, 1, 0, -1);
    check("t1_devid", 32'(rx[0]), 32'hE5);
    frame(8'hC0, 64, 0, -1);
    check("rst_devid", 32'(rx[0]), 32'hE5);
    check("rst_bw_rate", 32'(rx[44]), 32'h0A);
    check("rst_reserved", 32'(rx[5]), 32'h00);
    // T2
    tx = '{8'h08};
    frame(8'h2D, 1, 0, -1);
    frame(8'hAD, 1, 0, -1);
    check("t2_power_ctl", 32'(rx[0]), 32'h08);
    tx = '{8'h12};
    frame(8'h00, 1, 0, -1);
    frame(8'h80, 1, 0, -1);
    check("t2_devid_ro", 32'(rx[0]), 32'hE5);
    // T3
    tx = '{8'h80};
    frame(8'h2E, 1, 0, -1);
    do_sample(16'h0123, 16'hFF80, 16'h7FFF);
    half(10, 1'b0);
    check("t3_int1_set", 32'(int1), 1);
    frame(8'hF2, 6, 0, -1);
    exp6 = '{8'h23, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h7F};
    for (int i = 0; i < 6; i++) check("t3_data", 32'(rx[i]), 32'(exp6[i]));
    half(10, 1'b0);
    check("t3_int1_clr", 32'(int1), 0);
    // T4
    sample_x = 16'hAAAA; sample_y = 16'h5555; sample_z = 16'h1234;
    frame(8'hF2, 6, 0, 2);
    for (int i = 0; i < 6; i++) check("t4_old", 32'(rx[i]), 32'(exp6[i]));
    frame(8'hF2, 2, 0, -1);
    check("t4_new_x0", 32'(rx[0]), 32'hAA);
    check("t4_new_x1", 32'(rx[1]), 32'hAA);
    // T5
    frame(8'hB7, 1, 0, -1);
    do_sample(16'h1111, 16'h2222, 16'h3333);
    half(10, 1'b0);
    do_sample(16'h4444, 16'h5555, 16'h6666);
    frame(8'hB0, 1, 0, -1);
    check("t5_overrun", 32'(rx[0]), 32'h81);
    frame(8'hB7, 1, 0, -1);
    frame(8'hB0, 1, 0, -1);
    check("t5_cleared", 32'(rx[0]), 32'h00);
    // T6
    tx = '{8'h55};
    frame(8'h31, 1, 0, -1);
    tx = '{8'hAA};
    frame(8'h31, 0, 5, -1);
    frame(8'hB1, 1, 0, -1);
    check("t6_partial", 32'(rx[0]), 32'h55);
    noise();
    tx = '{8'h3C, 8'h99};
    frame(8'h7F, 2, 0, -1);
    frame(8'h80, 1, 0, -1);
    check("t6_wrap_devid", 32'(rx[0]), 32'hE5);
    frame(8'hBF, 1, 0, -1);
    check("t6_wrap_3f", 32'(rx[0]), 32'h3C);
    // Randomized traffic
    for (int n = 0; n < 30; n++) begin
      int op, nbytes;
      op = int'($urandom_range(0, 5));
      if (op == 0) do_sample(16'($urandom), 16'($urandom), 16'($urandom));
      else if (op == 1) noise();
      else begin
        nbytes = int'($urandom_range(1, 4));
        tx.delete();
        for (int i = 0; i < 5; i++) tx.push_back(8'($urandom));
        sample_x = 16'($urandom); sample_y = 16'($urandom); sample_z = 16'($urandom);
        frame(8'($urandom), nbytes, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nbytes - 1)) : -1);
      end
      half(12, 1'b0);
    end
    half(12, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
